uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_sched_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// ============================================================================
// Module  : uart_sched_pkg
// Brief   : Shared types and codes for the UART transmit scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    localparam logic [1:0] c_PAR_NONE   = 2'b00;
    localparam logic [1:0] c_PAR_ODD    = 2'b01;
    localparam logic [1:0] c_PAR_EVEN   = 2'b10;

    localparam logic [1:0] c_BAUD_4800  = 2'b01;
    localparam logic [1:0] c_BAUD_9600  = 2'b10;
    localparam logic [1:0] c_BAUD_19200 = 2'b11;

    localparam logic [7:0] c_RST_DATA   = 8'h00;
    localparam logic [1:0] c_RST_PARITY = c_PAR_NONE;
    localparam logic [1:0] c_RST_BAUD   = c_BAUD_9600;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; search starts after i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Shares one UART transmitter among NUM_REQ requesters, one frame at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SEND_HOLD = 16,
    parameter int TIMEOUT   = 1000000,
    parameter int GAP       = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [1:0]           i_cfg_parity_type,
    input  logic [1:0]           i_cfg_baud_rate,
    input  logic                 i_power_good,
    input  logic                 i_tx_done_flag,
    output logic                 o_send,
    output logic [7:0]           o_data_in,
    output logic [1:0]           o_parity_type,
    output logic [1:0]           o_baud_rate,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_abort,
    output logic                 o_busy
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_TW    = $clog2(TIMEOUT + 1);
    localparam int c_HW    = $clog2(SEND_HOLD + 1);
    localparam int c_GW    = $clog2(GAP + 1);

    localparam logic [c_TW-1:0]    c_TMO_PRE   = c_TW'(TIMEOUT - 2);
    localparam logic [c_TW-1:0]    c_TMO_LAST  = c_TW'(TIMEOUT - 1);
    localparam logic [c_HW-1:0]    c_HOLD_LAST = c_HW'(SEND_HOLD - 1);
    localparam logic [c_GW-1:0]    c_GAP_LAST  = c_GW'(GAP - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RST   = c_PTR_W'(NUM_REQ - 1);

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_TW-1:0]      r_tcnt;
    logic [c_HW-1:0]      r_hcnt;
    logic [c_GW-1:0]      r_gcnt;
    logic                 r_tx_d;
    logic                 r_send;
    logic [7:0]           r_data;
    logic [1:0]           r_par;
    logic [1:0]           r_baud;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_abort;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [7:0]           w_sel_data;
    logic [c_PTR_W-1:0]   w_sel_idx;
    logic                 w_active;
    logic                 w_rise;
    logic                 w_tmo;
    logic                 w_abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_arbiter (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) begin
                w_sel_data = i_req_data[8*i +: 8];
                w_sel_idx  = c_PTR_W'(i);
            end
        end
    end

    // The registered counter value is one behind, so abort lands on the TIMEOUT-1 cycle.
    assign w_active = (r_state == ST_SEND) || (r_state == ST_WAIT_DONE);
    assign w_rise   = i_tx_done_flag & ~r_tx_d;
    assign w_tmo    = (r_tcnt == c_TMO_PRE);
    assign w_abort  = w_active &&
                      (!i_power_good ||
                       (w_tmo && !((r_state == ST_WAIT_DONE) && w_rise)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_PTR_RST;
            r_tcnt  <= '0;
            r_hcnt  <= '0;
            r_gcnt  <= '0;
            r_tx_d  <= 1'b0;
            r_send  <= 1'b0;
            r_data  <= c_RST_DATA;
            r_par   <= c_RST_PARITY;
            r_baud  <= c_RST_BAUD;
            r_grant <= '0;
            r_done  <= '0;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_tx_d  <= i_tx_done_flag;
            r_done  <= '0;
            r_abort <= 1'b0;
            if (r_tcnt != c_TMO_LAST) begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end

            if (w_abort) begin
                r_abort <= 1'b1;
                r_send  <= 1'b0;
                r_grant <= '0;
                r_gcnt  <= '0;
                r_state <= ST_GAP;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_power_good && (|i_req)) begin
                            r_state <= ST_SEND;
                            r_busy  <= 1'b1;
                            r_send  <= 1'b1;
                            r_grant <= w_arb_grant;
                            r_ptr   <= w_sel_idx;
                            r_data  <= w_sel_data;
                            r_par   <= i_cfg_parity_type;
                            r_baud  <= i_cfg_baud_rate;
                            r_tcnt  <= '0;
                            r_hcnt  <= '0;
                        end
                    end
                    ST_SEND: begin
                        if (r_hcnt == c_HOLD_LAST) begin
                            r_send  <= 1'b0;
                            r_state <= ST_WAIT_DONE;
                        end else begin
                            r_hcnt <= r_hcnt + c_HW'(1);
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (w_rise) begin
                            r_done  <= r_grant;
                            r_grant <= '0;
                            r_gcnt  <= '0;
                            r_state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (r_gcnt == c_GAP_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gcnt <= r_gcnt + c_GW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_send        = r_send;
    assign o_data_in     = r_data;
    assign o_parity_type = r_par;
    assign o_baud_rate   = r_baud;
    assign o_grant       = r_grant;
    assign o_done        = r_done;
    assign o_abort       = r_abort;
    assign o_busy        = r_busy;

endmodule

`default_nettype wire
